// File: rtl/capture_pkg.sv
// Shared types and sizing helpers for the capture sequencer.
package capture_pkg;

    localparam int CAP_ADDR_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ARMED,
        ST_POST,
        ST_DONE
    } cap_state_t;

    function automatic int cap_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/capture_ctrl.sv
// Capture sequencer: circular RAM write addressing with a programmable pre/post-trigger split.
// Optional timeout trigger while armed is built when CAPTURE_AUTO_TRIG_EN is defined.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W          = CAP_ADDR_W,
    parameter int AUTO_TRIG_SMPLS = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              clr_done,
    input  logic              wrt_smpl,
    input  logic              triggered,
    input  logic [ADDR_W-1:0] trig_pos,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic              armed,
    output logic              busy,
    output logic              capture_done,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] rd_start,
    output logic              auto_trig
);

    localparam int              DEPTH   = cap_depth(ADDR_W);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_V   = (ADDR_W + 1)'(1);

    if (AUTO_TRIG_SMPLS < 1) begin : g_param_chk
        $error("AUTO_TRIG_SMPLS must be at least 1");
    end

    cap_state_t        state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] tpos_q, tpos_d;
    logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [ADDR_W:0]   post_cnt_q, post_cnt_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] rd_start_q, rd_start_d;
    logic              armed_q, armed_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              take;
    logic [ADDR_W:0]   post_left;

`ifdef CAPTURE_AUTO_TRIG_EN
    localparam int            AT_W    = $clog2(AUTO_TRIG_SMPLS + 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_TRIG_SMPLS - 1);
    logic [AT_W-1:0] atmr_q, atmr_d;
    logic            auto_q, auto_d;
`endif

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        tpos_d      = tpos_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_addr_d = trig_addr_q;
        rd_start_d  = rd_start_q;
        done_d      = done_q;
        take        = 1'b0;
        post_left   = '0;
`ifdef CAPTURE_AUTO_TRIG_EN
        atmr_d      = atmr_q;
        auto_d      = auto_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run) begin
                    tpos_d    = trig_pos;
                    pre_cnt_d = '0;
                    done_d    = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
                    atmr_d    = '0;
                    auto_d    = 1'b0;
`endif
                    state_d   = (trig_pos == '0) ? ST_ARMED : ST_PRE;
                end else if (state_q == ST_DONE && clr_done) begin
                    done_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (wrt_smpl) begin
                    waddr_d   = waddr_q + 1'b1;
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    if (pre_cnt_d == tpos_q) state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                take = triggered;
`ifdef CAPTURE_AUTO_TRIG_EN
                if (wrt_smpl) begin
                    atmr_d = atmr_q + 1'b1;
                    if (!triggered && atmr_q == AT_LAST) begin
                        take   = 1'b1;
                        auto_d = 1'b1;
                    end
                end
`endif
                if (wrt_smpl) waddr_d = waddr_q + 1'b1;
                // A write in the trigger cycle is the trigger sample and counts as the first post sample.
                if (take) begin
                    trig_addr_d = waddr_q;
                    post_left   = DEPTH_V - {1'b0, tpos_q};
                    if (wrt_smpl) post_left = post_left - ONE_V;
                    post_cnt_d  = post_left;
                    state_d     = (post_left == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (wrt_smpl) begin
                    waddr_d    = waddr_q + 1'b1;
                    post_cnt_d = post_cnt_q - ONE_V;
                    if (post_cnt_q == ONE_V) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // After exactly DEPTH writes the write pointer sits on the oldest sample.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d     = 1'b1;
            rd_start_d = waddr_d;
        end
        busy_d  = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
        armed_d = (state_d == ST_ARMED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            waddr_q     <= '0;
            tpos_q      <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_addr_q <= '0;
            rd_start_q  <= '0;
            armed_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
            atmr_q      <= '0;
            auto_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            tpos_q      <= tpos_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_addr_q <= trig_addr_d;
            rd_start_q  <= rd_start_d;
            armed_q     <= armed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef CAPTURE_AUTO_TRIG_EN
            atmr_q      <= atmr_d;
            auto_q      <= auto_d;
`endif
        end
    end

    assign we           = wrt_smpl & busy_q;
    assign waddr        = waddr_q;
    assign armed        = armed_q;
    assign busy         = busy_q;
    assign capture_done = done_q;
    assign trig_addr    = trig_addr_q;
    assign rd_start     = rd_start_q;
`ifdef CAPTURE_AUTO_TRIG_EN
    assign auto_trig    = auto_q;
`else
    assign auto_trig    = 1'b0;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl (ADDR_W=4, DEPTH=16, one sample every 4th clock).
// Follows CAPTURE_AUTO_TRIG_EN the same way as the design.
module tb_capture_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       clr_done;
    logic       wrt_smpl;
    logic       triggered;
    logic [3:0] trig_pos;
    logic       we;
    logic [3:0] waddr;
    logic       armed;
    logic       busy;
    logic       capture_done;
    logic [3:0] trig_addr;
    logic [3:0] rd_start;
    logic       auto_trig;

    always #5 clk = ~clk;

    capture_ctrl #(
        .ADDR_W          (4),
        .AUTO_TRIG_SMPLS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .clr_done     (clr_done),
        .wrt_smpl     (wrt_smpl),
        .triggered    (triggered),
        .trig_pos     (trig_pos),
        .we           (we),
        .waddr        (waddr),
        .armed        (armed),
        .busy         (busy),
        .capture_done (capture_done),
        .trig_addr    (trig_addr),
        .rd_start     (rd_start),
        .auto_trig    (auto_trig)
    );

    // is_done=0: a RAM write at address a; is_done=1: done with trig_addr a, rd_start b, auto_trig c
    typedef struct packed {
        logic       is_done;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
    } exp_t;

    exp_t       sb_q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    logic [3:0] exp_addr;
    logic       done_prev;

    function automatic void check(input string name, input int act, input int req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Monitor: pops one expectation per write pulse and per rising capture_done.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (we) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_we: got write at %0d, expected no write", waddr);
                end else begin
                    e = sb_q.pop_front();
                    check("event_is_write", 32'(e.is_done), 0);
                    check("waddr", 32'(waddr), 32'(e.a));
                end
            end
            if (capture_done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got done trig_addr=%0d, expected no done", trig_addr);
                end else begin
                    e = sb_q.pop_front();
                    check("event_is_done", 32'(e.is_done), 1);
                    check("trig_addr", 32'(trig_addr), 32'(e.a));
                    check("rd_start", 32'(rd_start), 32'(e.b));
                    check("auto_trig_at_done", 32'(auto_trig), 32'(e.c));
                end
            end
            done_prev = capture_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Four clocks with the write on the last; triggered held for the whole group.
    task automatic sample(input logic trg, input logic exp_we);
        for (int i = 0; i < 4; i++) begin
            wrt_smpl  = (i == 3);
            triggered = trg;
            if (i == 3 && exp_we) begin
                sb_q.push_back('{1'b0, exp_addr, 4'd0, 1'b0});
                exp_addr = exp_addr + 4'd1;
            end
            tick();
        end
        wrt_smpl  = 1'b0;
        triggered = 1'b0;
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) sample(1'b0, 1'b1);
    endtask

    task automatic pulse_run(input logic [3:0] tp);
        trig_pos = tp;
        run      = 1'b1;
        tick();
        run      = 1'b0;
    endtask

    task automatic expect_done(input logic [3:0] ta, input logic [3:0] rs, input logic at);
        sb_q.push_back('{1'b1, ta, rs, at});
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        check(name, sb_q.size(), 0);
        #1;
    endtask

    task automatic pulse_clr();
        clr_done = 1'b1;
        tick();
        clr_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; run = 1'b0; clr_done = 1'b0; wrt_smpl = 1'b0; triggered = 1'b0;
        trig_pos = 4'd0; exp_addr = 4'd0; done_prev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_armed", 32'(armed), 0);
        check("rst_done", 32'(capture_done), 0);
        check("rst_waddr", 32'(waddr), 0);
        check("rst_trig_addr", 32'(trig_addr), 0);
        check("rst_rd_start", 32'(rd_start), 0);
        check("rst_auto", 32'(auto_trig), 0);
        rst = 1'b0;
        tick();

        // trig_pos=4, trigger after 10 writes
        pulse_run(4'd4);
        check("t2_busy", 32'(busy), 1);
        check("t2_not_armed", 32'(armed), 0);
        samples(4);
        check("t2_armed", 32'(armed), 1);
        samples(6);
        sample(1'b1, 1'b1);
        samples(11);
        expect_done(4'd10, 4'd6, 1'b0);
        drain("t2_scoreboard_empty");
        check("t2_done", 32'(capture_done), 1);
        check("t2_busy_done", 32'(busy), 0);
        check("t2_waddr", 32'(waddr), 6);
        sample(1'b1, 1'b0);

        // second run from DONE, wrap 15->0, run while busy ignored
        pulse_run(4'd4);
        check("t5_done_cleared", 32'(capture_done), 0);
        check("t5_busy", 32'(busy), 1);
        pulse_run(4'd9);
        samples(4);
        check("t5_armed", 32'(armed), 1);
        samples(6);
        sample(1'b1, 1'b1);
        samples(11);
        expect_done(4'd0, 4'd12, 1'b0);
        drain("t5_scoreboard_empty");
        check("t5_waddr", 32'(waddr), 12);
        pulse_clr();
        check("clr_done", 32'(capture_done), 0);
        check("clr_busy", 32'(busy), 0);

        // reset in the middle of POST
        pulse_run(4'd2);
        samples(2);
        sample(1'b1, 1'b1);
        samples(1);
        check("t1_in_post", 32'(busy), 1);
        rst = 1'b1;
        wrt_smpl = 1'b1;
        #1;
        check("t1_rst_busy", 32'(busy), 0);
        check("t1_rst_we", 32'(we), 0);
        check("t1_rst_waddr", 32'(waddr), 0);
        check("t1_rst_trig_addr", 32'(trig_addr), 0);
        check("t1_rst_armed", 32'(armed), 0);
        wrt_smpl = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("t1_waddr_after", 32'(waddr), 0);
        check("t1_done_after", 32'(capture_done), 0);
        exp_addr = 4'd0;
        drain("t1_scoreboard_empty");

        // trig_pos=0, trigger already high at run
        triggered = 1'b1;
        pulse_run(4'd0);
        check("t3_armed_now", 32'(armed), 1);
        for (int i = 0; i < 16; i++) sample(1'b1, 1'b1);
        expect_done(4'd0, 4'd0, 1'b0);
        drain("t3_scoreboard_empty");
        check("t3_waddr", 32'(waddr), 0);

        // trig_pos=15, trigger in PRE ignored, one post write
        pulse_run(4'd15);
        for (int i = 0; i < 15; i++) sample(i == 4, 1'b1);
        check("t4_armed", 32'(armed), 1);
        samples(1);
        check("t4_still_armed", 32'(armed), 1);
        sample(1'b1, 1'b1);
        expect_done(4'd0, 4'd1, 1'b0);
        drain("t4_scoreboard_empty");
        check("t4_waddr", 32'(waddr), 1);

        // run and clr_done in the same clock: run wins
        trig_pos = 4'd2;
        run = 1'b1;
        clr_done = 1'b1;
        tick();
        run = 1'b0;
        clr_done = 1'b0;
        check("t6_run_wins_busy", 32'(busy), 1);
        check("t6_run_wins_done", 32'(capture_done), 0);
        samples(2);
        check("t6_armed", 32'(armed), 1);
`ifdef CAPTURE_AUTO_TRIG_EN
        samples(8);
        samples(13);
        expect_done(4'd10, 4'd8, 1'b1);
        drain("t6_scoreboard_empty");
        check("t6_auto_trig", 32'(auto_trig), 1);
        pulse_run(4'd0);
        check("t6_auto_cleared", 32'(auto_trig), 0);
`else
        samples(10);
        drain("t6_scoreboard_empty");
        check("t6_stays_armed", 32'(armed), 1);
        check("t6_no_done", 32'(capture_done), 0);
        check("t6_auto_tied", 32'(auto_trig), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
